// File: rtl/cell_draw_sequencer.sv
// Queues changed-cell reports and expands each into a window command plus TILE_PX^2 RGB565 beats.
// Optional macro CELL_DRAW_DEDUP_EN: a push matching a queued (x,y) overwrites that entry's code.
module cell_draw_sequencer #(
    parameter int unsigned TILE_PX    = 20,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GRID_W     = 16,
    parameter int unsigned GRID_H     = 12
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        cell_valid,
    input  logic [3:0]  cell_x,
    input  logic [3:0]  cell_y,
    input  logic [2:0]  cell_code,
    output logic        cell_ready,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [8:0]  win_x0,
    output logic [8:0]  win_x1,
    output logic [7:0]  win_y0,
    output logic [7:0]  win_y1,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_data,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned NBeats = TILE_PX * TILE_PX;
    localparam int unsigned BeatW  = (NBeats > 1) ? $clog2(NBeats) : 1;

    typedef enum logic [1:0] {StIdle, StWin, StPix} state_e;

    state_e            state_q;
    logic [3:0]        fifo_x_q [FIFO_DEPTH];
    logic [3:0]        fifo_y_q [FIFO_DEPTH];
    logic [2:0]        fifo_c_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q;
    logic              win_valid_q, pix_valid_q;
    logic [8:0]        win_x0_q, win_x1_q;
    logic [7:0]        win_y0_q, win_y1_q;
    logic [15:0]       pix_data_q;
    logic [BeatW-1:0]  beat_q;

    logic              in_range, full, pop, push, hit, drop;
    logic [PtrW-1:0]   hit_idx;

    function automatic logic [15:0] colour(input logic [2:0] code);
        case (code)
            3'b000:  colour = 16'h0000;
            3'b001:  colour = 16'h07E0;
            3'b010:  colour = 16'h03E0;
            3'b011:  colour = 16'hF800;
            3'b100:  colour = 16'hFFFF;
            default: colour = 16'hF81F;
        endcase
    endfunction

    always_comb begin
        in_range = cell_valid && (32'(cell_x) < GRID_W) && (32'(cell_y) < GRID_H);
        full     = (count_q == CntW'(FIFO_DEPTH));
        pop      = (state_q == StIdle) && (count_q != '0);
    end

`ifdef CELL_DRAW_DEDUP_EN
    logic [PtrW-1:0] slot_off;

    // The head being popped this cycle is already leaving, so it is not a match candidate.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        slot_off = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            slot_off = PtrW'(i) - rd_ptr_q;
            if ((CntW'(slot_off) < count_q) && !(pop && (slot_off == '0)) &&
                (fifo_x_q[i] == cell_x) && (fifo_y_q[i] == cell_y)) begin
                hit     = 1'b1;
                hit_idx = PtrW'(i);
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_idx = '0;
`endif

    always_comb begin
        push = in_range && !hit && !full;
        drop = in_range && !hit && full;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x_q[wr_ptr_q] <= cell_x;
            fifo_y_q[wr_ptr_q] <= cell_y;
            fifo_c_q[wr_ptr_q] <= cell_code;
        end
        if (in_range && hit) fifo_c_q[hit_idx] <= cell_code;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            win_valid_q <= 1'b0;
            pix_valid_q <= 1'b0;
            win_x0_q    <= '0;
            win_x1_q    <= '0;
            win_y0_q    <= '0;
            win_y1_q    <= '0;
            pix_data_q  <= '0;
            beat_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        win_x0_q    <= 9'(32'(fifo_x_q[rd_ptr_q]) * TILE_PX);
                        win_x1_q    <= 9'(32'(fifo_x_q[rd_ptr_q]) * TILE_PX + TILE_PX - 1);
                        win_y0_q    <= 8'(32'(fifo_y_q[rd_ptr_q]) * TILE_PX);
                        win_y1_q    <= 8'(32'(fifo_y_q[rd_ptr_q]) * TILE_PX + TILE_PX - 1);
                        pix_data_q  <= colour(fifo_c_q[rd_ptr_q]);
                        win_valid_q <= 1'b1;
                        state_q     <= StWin;
                    end
                end
                StWin: begin
                    if (win_ready) begin
                        win_valid_q <= 1'b0;
                        pix_valid_q <= 1'b1;
                        beat_q      <= '0;
                        state_q     <= StPix;
                    end
                end
                StPix: begin
                    if (pix_ready) begin
                        if (beat_q == BeatW'(NBeats - 1)) begin
                            pix_valid_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            beat_q <= beat_q + BeatW'(1);
                        end
                    end
                end
                default: begin
                    win_valid_q <= 1'b0;
                    pix_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign cell_ready = !full;
    assign win_valid  = win_valid_q;
    assign win_x0     = win_x0_q;
    assign win_x1     = win_x1_q;
    assign win_y0     = win_y0_q;
    assign win_y1     = win_y1_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_cell_draw_sequencer.sv
// Cycle-level scoreboard bench for cell_draw_sequencer: directed scenarios then random traffic.
// Honours CELL_DRAW_DEDUP_EN in its reference model.
module tb_cell_draw_sequencer;

    localparam int TP = 20;
    localparam int D  = 8;
    localparam int GW = 16;
    localparam int GH = 12;
    localparam int NB = TP * TP;
`ifdef CELL_DRAW_DEDUP_EN
    localparam bit ExpOvf = 1'b0;
`else
    localparam bit ExpOvf = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cell_valid = 1'b0;
    logic [3:0]  cell_x = '0;
    logic [3:0]  cell_y = '0;
    logic [2:0]  cell_code = '0;
    logic        win_ready = 1'b0;
    logic        pix_ready = 1'b0;
    logic        cell_ready, win_valid, pix_valid, busy, overflow;
    logic [8:0]  win_x0, win_x1;
    logic [7:0]  win_y0, win_y1;
    logic [15:0] pix_data;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;

    // Reference model: queued cells, the tile in flight and its progress.
    int mq_x[$];
    int mq_y[$];
    int mq_c[$];
    bit m_act, m_win, m_ovf;
    int m_beat, m_tx, m_ty, m_tc;

    cell_draw_sequencer #(
        .TILE_PX(TP), .FIFO_DEPTH(D), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .clk(clk), .nrst(nrst),
        .cell_valid(cell_valid), .cell_x(cell_x), .cell_y(cell_y), .cell_code(cell_code),
        .cell_ready(cell_ready),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_colour(input int c);
        case (c)
            0:       ref_colour = 16'h0000;
            1:       ref_colour = 16'h07E0;
            2:       ref_colour = 16'h03E0;
            3:       ref_colour = 16'hF800;
            4:       ref_colour = 16'hFFFF;
            default: ref_colour = 16'hF81F;
        endcase
    endfunction

    task automatic model_reset();
        mq_x.delete();
        mq_y.delete();
        mq_c.delete();
        m_act = 1'b0;
        m_win = 1'b0;
        m_ovf = 1'b0;
        m_beat = 0;
    endtask

    // Advance the model by one clock edge using the inputs as they stand before the edge.
    task automatic model_edge();
        bit do_pop, in_r;
        int hit;
        if (!nrst) begin
            model_reset();
            return;
        end
        do_pop = !m_act && (mq_x.size() > 0);
        in_r   = cell_valid && (int'(cell_x) < GW) && (int'(cell_y) < GH);
        hit    = -1;
`ifdef CELL_DRAW_DEDUP_EN
        for (int i = (do_pop ? 1 : 0); i < mq_x.size(); i++)
            if (mq_x[i] == int'(cell_x) && mq_y[i] == int'(cell_y)) hit = i;
`endif
        if (in_r) begin
            if (hit >= 0) mq_c[hit] = int'(cell_code);
            else if (mq_x.size() < D) begin
                mq_x.push_back(int'(cell_x));
                mq_y.push_back(int'(cell_y));
                mq_c.push_back(int'(cell_code));
            end else m_ovf = 1'b1;
        end
        if (m_act) begin
            if (m_win) begin
                if (win_ready) begin
                    m_win = 1'b0;
                    m_beat = 0;
                end
            end else if (pix_ready) begin
                if (m_beat == NB - 1) m_act = 1'b0;
                else m_beat++;
            end
        end else if (do_pop) begin
            m_tx = mq_x.pop_front();
            m_ty = mq_y.pop_front();
            m_tc = mq_c.pop_front();
            m_act = 1'b1;
            m_win = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_eq("flags", 64'({cell_ready, win_valid, pix_valid, busy, overflow}),
                 64'({mq_x.size() < D, m_act && m_win, m_act && !m_win,
                      m_act || (mq_x.size() > 0), m_ovf}));
        if (m_act && m_win)
            check_eq("window", 64'({win_x0, win_x1, win_y0, win_y1}),
                     64'({9'(m_tx * TP), 9'(m_tx * TP + TP - 1),
                          8'(m_ty * TP), 8'(m_ty * TP + TP - 1)}));
        if (m_act && !m_win)
            check_eq("pixel", 64'(pix_data), 64'(ref_colour(m_tc)));
    endtask

    task automatic step();
        model_edge();
        if (nrst && pix_valid && pix_ready) hs_cnt++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic push_cell(input int x, input int y, input int c);
        cell_valid = 1'b1;
        cell_x = 4'(x);
        cell_y = 4'(y);
        cell_code = 3'(c);
        step();
        cell_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check_eq("drain", 64'(busy), 64'(0));
    endtask

    initial begin
        model_reset();
        #22 nrst = 1'b1;
        check_outputs();
        check_eq("rst_fields", 64'({win_x0, win_x1, win_y0, win_y1, pix_data}), 64'(0));
        repeat (10) step();

        // Single tile, driver always ready.
        win_ready = 1'b1;
        pix_ready = 1'b1;
        hs_cnt = 0;
        push_cell(4, 4, 1);
        drain(1000);
        check_eq("t2_beats", 64'(hs_cnt), 64'(NB));

        // Pixel backpressure on alternate cycles.
        hs_cnt = 0;
        push_cell(6, 4, 3);
        for (int n = 0; n < 2000 && busy; n++) begin
            pix_ready = ~pix_ready;
            step();
        end
        check_eq("t3_beats", 64'(hs_cnt), 64'(NB));
        check_eq("t3_idle", 64'(busy), 64'(0));

        // Fill the queue behind a stalled window.
        win_ready = 1'b0;
        pix_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
`ifdef CELL_DRAW_DEDUP_EN
            if (i == 9) push_cell(2, 5, 7);
            else push_cell(i, 5, i % 5 + 1);
`else
            push_cell(i, 5, i % 5 + 1);
`endif
        end
        check_eq("t4_full", 64'(cell_ready), 64'(0));
        check_eq("t4_ovf", 64'(overflow), 64'(ExpOvf));
        win_ready = 1'b1;
        hs_cnt = 0;
        drain(6000);
        check_eq("t4_beats", 64'(hs_cnt), 64'(9 * NB));

        // Corner cell, then an out-of-range row.
        push_cell(15, 11, 4);
        drain(1000);
        push_cell(3, 12, 1);
        repeat (5) step();
        check_eq("t5_oob", 64'({win_valid, busy}), 64'(0));

        // Reset in the middle of a tile.
        hs_cnt = 0;
        push_cell(1, 2, 2);
        push_cell(3, 4, 3);
        for (int n = 0; n < 500 && hs_cnt < 100; n++) step();
        check_eq("t6_reach", 64'(hs_cnt), 64'(100));
        #2 nrst = 1'b0;
        #1 check_eq("t6_rst", 64'({pix_valid, win_valid, busy, overflow, cell_ready}),
                    64'(5'b00001));
        model_reset();
        step();
        step();
        nrst = 1'b1;
        hs_cnt = 0;
        repeat (30) step();
        check_eq("t6_quiet", 64'(hs_cnt), 64'(0));

        // Random traffic with random backpressure.
        for (int n = 0; n < 8000; n++) begin
            cell_valid = ($urandom_range(0, 39) == 0);
            cell_x = 4'($urandom);
            cell_y = 4'($urandom);
            cell_code = 3'($urandom);
            win_ready = ($urandom_range(0, 9) < 7);
            pix_ready = ($urandom_range(0, 9) < 8);
            step();
        end
        cell_valid = 1'b0;
        win_ready = 1'b1;
        pix_ready = 1'b1;
        drain(8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cell_draw_sequencer.md
Name: cell_draw_sequencer

Overview:
- Sits directly downstream of frame_tracker and upstream of the display driver.
- Accepts changed-cell reports (x, y, obj_code) for the 16x12 game grid, queues them in a small FIFO, and converts each one into a pixel window command plus a stream of TILE_PX*TILE_PX RGB565 pixels.
- Both output channels use valid/ready handshakes.

Parameters:
TILE_PX, 20, tile edge in pixels (grid maps onto a 320x240 panel)
FIFO_DEPTH, 8, cell queue depth; power of 2, minimum 2
GRID_W, 16, grid columns
GRID_H, 12, grid rows

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
cell_valid  input  1  cell report strobe (frame_tracker diff qualified by enable)
cell_x  input  4  cell column
cell_y  input  4  cell row
cell_code  input  3  obj_code: 000 empty, 001 head, 010 body, 011 apple, 100 border
cell_ready  output  1  queue can accept a report
win_valid  output  1  window command valid
win_ready  input  1  driver accepts window
win_x0  output  9  left pixel = cell_x*TILE_PX
win_x1  output  9  right pixel = win_x0+TILE_PX-1
win_y0  output  8  top pixel = cell_y*TILE_PX
win_y1  output  8  bottom pixel = win_y0+TILE_PX-1
pix_valid  output  1  pixel beat valid
pix_ready  input  1  driver accepts pixel
pix_data  output  16  RGB565 colour
busy  output  1  state != IDLE or FIFO non-empty
overflow  output  1  sticky: a report was dropped because the queue was full

Behaviour:
- Reset (asynchronous, nrst low): FIFO empty, state IDLE, pixel counter 0, overflow 0. All outputs 0 except cell_ready=1. Reset takes effect at any point, including mid-stream, and aborts the current tile with no further beats.
- Push: occurs when cell_valid=1, cell_ready=1, and cell_y<GRID_H and cell_x<GRID_W.
  - Out-of-range coordinates are discarded silently. No flag is raised.
- cell_ready = (count != FIFO_DEPTH). A cell_valid=1 report while the queue is full is dropped and sets overflow, which stays set until reset.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- FSM:
  - IDLE: if FIFO non-empty, pop the head entry into the tile registers and go to WIN.
  - WIN: win_valid=1 and window fields held stable. On win_valid&&win_ready, clear the pixel counter and go to PIX.
  - PIX: pix_valid=1 and pix_data = colour(code) held stable. Each pix_ready handshake increments the counter.
    - Handshake at counter TILE_PX*TILE_PX-1: go to IDLE. pix_valid deasserts the next cycle.
- Latency: a push captured at edge E gives win_valid high after edge E+1 when the FSM is in IDLE.
- Idle gap: exactly 1 cycle in IDLE between tiles.
- Beat order: row-major within the window, 400 beats for the default TILE_PX.
- Colour map:
  - 000 -> 16'h0000
  - 001 -> 16'h07E0
  - 010 -> 16'h03E0
  - 011 -> 16'hF800
  - 100 -> 16'hFFFF
  - 101-111 -> 16'hF81F
- Window arithmetic: full-width products with no truncation. x up to 319 fits 9 bits; y up to 239 fits 8 bits.
- Output stability: win_* and pix_data do not change while their valid is high and ready is low.
- busy goes low the cycle after the final beat, provided the FIFO is empty.

Optional Feature:
CELL_DRAW_DEDUP_EN
- Defined: a push whose (x,y) matches an entry still in the FIFO overwrites that entry's code in place.
  - Count is unchanged and the entry's queue position is unchanged.
  - A dedup push is accepted even when the FIFO is full (no overflow).
  - The tile currently in WIN/PIX is not a FIFO entry and is never matched.
- Undefined: every valid push takes a new entry.

Test Plan:
1. Reset with all inputs 0 -> cell_ready=1, and win_valid, pix_valid, busy, overflow all 0. Ten idle cycles: outputs unchanged.
2. Push (4,4,001) with win_ready=pix_ready=1 -> win_valid after E+1 with window (80,99,80,99), then 400 beats of 16'h07E0, then busy=0.
3. Push (6,4,011) with pix_ready toggling 1,0 each cycle -> pix_data holds 16'hF800 through stalls, exactly 400 accepted beats, FSM returns to IDLE.
4. win_ready=0, push 10 distinct cells back-to-back:
   - 1st is held in WIN and the next 8 fill the FIFO, so cell_ready=0.
   - 10th is dropped and overflow=1.
   - Release ready: 9 tiles emitted in push order.
   - With CELL_DRAW_DEDUP_EN, a repeat of cell 3 while full overwrites its code and overflow stays 0.
5. Push (15,11,100) -> window (300,319,220,239) and pix_data 16'hFFFF. Push (3,12,001) -> ignored: no win_valid, count unchanged.
6. Push two cells, drop nrst after 100 beats of the first tile -> pix_valid=0 immediately, busy=0, FIFO empty. After release, no beats are emitted.
